niosii_system_mul_cell_arbiter: RTL and testbench

//  Shares one pipelined 32x32->32 (low-word) multiplier cell between NUM_REQ requesters.

---
 rtl/niosii_system_mul_cell_arbiter.sv | 166 ++++++++++++++++
 tb/tb_niosii_system_mul_cell_arbiter.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/niosii_system_mul_cell_arbiter.sv
// -----------------------------------------------------------------------------
// niosii_system_mul_cell_arbiter
//
// Shares one external pipelined multiplier cell (DATA_W x DATA_W -> low DATA_W)
// between NUM_REQ requesters. A round-robin arbiter picks at most one eligible
// requester per cycle and muxes its operands onto mul_src1/mul_src2. The
// winner's index travels alongside the operation in a tag pipeline whose depth
// matches the cell latency. When the tag leaves the last stage, the cell result
// is steered into that requester's response holding register.
//
// Each requester may have only one operation outstanding. It is eligible only
// when it has nothing in flight and no unconsumed response. Because each
// requester is exclusive in this way, two writebacks can never target the same
// slot.
//
// Ports
//   clk              system clock, all logic on the rising edge
//   reset            synchronous, active-high
//   req_valid        [NUM_REQ]         per-requester operation request
//   req_ready        [NUM_REQ]         grant this cycle (one-hot or zero)
//   req_a, req_b     [NUM_REQ*DATA_W]  packed operands, requester i at [i*DATA_W +: DATA_W]
//   rsp_valid        [NUM_REQ]         result held for requester i
//   rsp_ready        [NUM_REQ]         requester i consumes its result
//   rsp_result       [NUM_REQ*DATA_W]  packed results, same packing
//   mul_src1/2       [DATA_W]          operands to the multiplier cell
//   mul_cell_result  [DATA_W]          low product bits from the cell
//   busy                               any operation in flight or response pending
// -----------------------------------------------------------------------------
module niosii_system_mul_cell_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int DATA_W      = 32,
  parameter int MUL_LATENCY = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_a,
  input  logic [NUM_REQ*DATA_W-1:0] req_b,
  output logic [NUM_REQ-1:0]        rsp_valid,
  input  logic [NUM_REQ-1:0]        rsp_ready,
  output logic [NUM_REQ*DATA_W-1:0] rsp_result,
  output logic [DATA_W-1:0]         mul_src1,
  output logic [DATA_W-1:0]         mul_src2,
  input  logic [DATA_W-1:0]         mul_cell_result,
  output logic                      busy
);

  localparam int TAG_W = $clog2(NUM_REQ);

  typedef logic [TAG_W-1:0] tag_t;

  // One stage of the tag pipeline: marks whether the multiplier slot holds a
  // live operation, and which requester owns it.
  typedef struct packed {
    logic vld;
    tag_t tag;
  } tag_stage_t;

  tag_t               rr_ptr;
  logic [NUM_REQ-1:0] inflight;
  logic [NUM_REQ-1:0] inflight_nxt;
  logic [NUM_REQ-1:0] rsp_valid_nxt;
  logic [NUM_REQ-1:0] elig;
  logic [NUM_REQ-1:0] grant;
  logic               grant_any;
  tag_t               winner;
  tag_stage_t         pipe [MUL_LATENCY];
  tag_stage_t         last_stage;

  assign last_stage = pipe[MUL_LATENCY-1];

  // A requester with an operation in flight or an unread response must wait.
  // This guarantees at most one outstanding operation per requester.
  assign elig = req_valid & ~inflight & ~rsp_valid;

  // ---------------------------------------------------------------------------
  // Round-robin arbitration. The search starts just past the last winner and
  // wraps around. After reset, rr_ptr = NUM_REQ-1, so index 0 is searched first.
  // ---------------------------------------------------------------------------
  always_comb begin : arbitrate
    int unsigned idx;
    // NOTE: every variable written in this block gets a default before any
    // conditional assignment; otherwise the paths that skip it infer latches.
    idx       = 0;
    grant     = '0;
    grant_any = 1'b0;
    winner    = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(rr_ptr) + k) % NUM_REQ;
      // No handshake may complete while reset is held.
      if (!grant_any && elig[idx] && !reset) begin
        grant[idx] = 1'b1;
        grant_any  = 1'b1;
        winner     = tag_t'(idx);
      end
    end
  end

  assign req_ready = grant;

  // Operand mux: idle cycles drive zeros rather than a stale requester's data.
  always_comb begin
    mul_src1 = '0;
    mul_src2 = '0;
    if (grant_any) begin
      mul_src1 = req_a[int'(winner)*DATA_W +: DATA_W];
      mul_src2 = req_b[int'(winner)*DATA_W +: DATA_W];
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state of the per-requester flags. The inflight clear (tag retiring)
  // and the set (new grant) always target different requesters, because a
  // requester with a retiring tag is still inflight and so is not eligible.
  // ---------------------------------------------------------------------------
  always_comb begin
    inflight_nxt  = inflight;
    rsp_valid_nxt = rsp_valid & ~rsp_ready;
    if (last_stage.vld) begin
      inflight_nxt[last_stage.tag]  = 1'b0;
      rsp_valid_nxt[last_stage.tag] = 1'b1;
    end
    inflight_nxt = inflight_nxt | grant;
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: non-blocking assignments for all state, so every register samples
      // pre-edge values regardless of statement order.
      rr_ptr    <= tag_t'(NUM_REQ - 1);
      inflight  <= '0;
      rsp_valid <= '0;
      // NOTE: the result holding registers are cleared too, because their value
      // is observable on rsp_result straight out of reset.
      rsp_result <= '0;
      for (int s = 0; s < MUL_LATENCY; s++) begin
        pipe[s] <= '0;
      end
    end else begin
      if (grant_any) begin
        rr_ptr <= winner;
      end
      inflight  <= inflight_nxt;
      rsp_valid <= rsp_valid_nxt;

      // The tag advances in lockstep with the operands inside the cell.
      pipe[0] <= '{vld: grant_any, tag: winner};
      for (int s = 1; s < MUL_LATENCY; s++) begin
        pipe[s] <= pipe[s-1];
      end

      if (last_stage.vld) begin
        rsp_result[int'(last_stage.tag)*DATA_W +: DATA_W] <= mul_cell_result;
      end
    end
  end

  // Derived only from registered state, so busy does not depend on this
  // cycle's requests.
  assign busy = (|inflight) | (|rsp_valid);

endmodule

// File: tb/tb_niosii_system_mul_cell_arbiter.sv
// -----------------------------------------------------------------------------
// tb_niosii_system_mul_cell_arbiter
//
// Directed bench for the multiplier-cell arbiter. The multiplier cell is
// modelled as a MUL_LATENCY-deep registered a*b. Inputs change 1 time unit
// after the rising edge. Outputs are sampled 1 unit later, well before the
// next edge.
// -----------------------------------------------------------------------------
module tb_niosii_system_mul_cell_arbiter;

  localparam int NUM_REQ     = 4;
  localparam int DATA_W      = 32;
  localparam int MUL_LATENCY = 1;

  logic                      clk = 1'b0;
  logic                      reset;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*DATA_W-1:0] req_a;
  logic [NUM_REQ*DATA_W-1:0] req_b;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [NUM_REQ-1:0]        rsp_ready;
  logic [NUM_REQ*DATA_W-1:0] rsp_result;
  logic [DATA_W-1:0]         mul_src1;
  logic [DATA_W-1:0]         mul_src2;
  logic [DATA_W-1:0]         mul_cell_result;
  logic                      busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  niosii_system_mul_cell_arbiter #(
    .NUM_REQ    (NUM_REQ),
    .DATA_W     (DATA_W),
    .MUL_LATENCY(MUL_LATENCY)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_a          (req_a),
    .req_b          (req_b),
    .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),
    .rsp_result     (rsp_result),
    .mul_src1       (mul_src1),
    .mul_src2       (mul_src2),
    .mul_cell_result(mul_cell_result),
    .busy           (busy)
  );

  // Multiplier cell model: registered low-word product, MUL_LATENCY deep.
  logic [DATA_W-1:0] cell_pipe [MUL_LATENCY];
  always_ff @(posedge clk) begin
    cell_pipe[0] <= mul_src1 * mul_src2;
    for (int s = 1; s < MUL_LATENCY; s++) begin
      cell_pipe[s] <= cell_pipe[s-1];
    end
  end
  assign mul_cell_result = cell_pipe[MUL_LATENCY-1];

  // Watchdog: the directed sequence is short, so this only trips on a hang.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  function automatic logic [DATA_W-1:0] res(input int i);
    return rsp_result[i*DATA_W +: DATA_W];
  endfunction

  task automatic set_ops(input int i, input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    req_a[i*DATA_W +: DATA_W] = a;
    req_b[i*DATA_W +: DATA_W] = b;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    req_valid = '0;
    rsp_ready = '1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // One isolated operation by requester idx, with rsp_ready held high.
  task automatic single_op(input int idx, input logic [DATA_W-1:0] a,
                           input logic [DATA_W-1:0] b, input logic [DATA_W-1:0] exp);
    logic [NUM_REQ-1:0] one;
    one = NUM_REQ'(1) << idx;
    set_ops(idx, a, b);
    req_valid = one;
    settle();
    check("single_grant", req_ready, one);
    check("single_src1", mul_src1, a);
    check("single_src2", mul_src2, b);
    tick();
    req_valid = '0;
    settle();
    check("single_no_rsp_yet", rsp_valid, '0);
    check("single_busy_inflight", busy, 1'b1);
    tick();
    settle();
    check("single_rsp_valid", rsp_valid, one);
    check("single_result", res(idx), exp);
    tick();
    settle();
    check("single_rsp_cleared", rsp_valid, '0);
    check("single_result_held", res(idx), exp);
    check("single_idle", busy, 1'b0);
  endtask

  logic [NUM_REQ-1:0] g3 [6];
  logic [NUM_REQ-1:0] v3 [6];
  logic [NUM_REQ-1:0] g4 [6];
  logic [NUM_REQ-1:0] g5 [5];
  logic               v5 [5];
  logic [DATA_W-1:0]  r5 [5];

  initial begin
    g3 = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
    v3 = '{4'b0000, 4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
    g4 = '{4'b0100, 4'b1000, 4'b0001, 4'b0100, 4'b1000, 4'b0001};
    g5 = '{4'b0000, 4'b0000, 4'b1000, 4'b0000, 4'b0000};
    v5 = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    r5 = '{32'd0, 32'd63, 32'd0, 32'd0, 32'd143};

    req_a = '0;
    req_b = '0;
    do_reset();

    // Reset state
    settle();
    check("rst_req_ready", req_ready, '0);
    check("rst_rsp_valid", rsp_valid, '0);
    check("rst_rsp_result", rsp_result, '0);
    check("rst_src1", mul_src1, '0);
    check("rst_src2", mul_src2, '0);
    check("rst_busy", busy, 1'b0);

    // 1. Single op
    single_op(0, 32'd3, 32'd5, 32'd15);

    // 2. Wraparound arithmetic
    single_op(2, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE);
    single_op(2, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000);

    // 3. Fairness: all requesters valid from reset
    do_reset();
    for (int i = 0; i < NUM_REQ; i++) set_ops(i, DATA_W'(i + 1), 32'd10);
    req_valid = '1;
    for (int c = 0; c < 6; c++) begin
      settle();
      check("rr_grant", req_ready, g3[c]);
      check("rr_rsp_valid", rsp_valid, v3[c]);
      if (c >= 2) check("rr_result", res(c - 2), DATA_W'((c - 1) * 10));
      if (c < 2) check("rr_src1", mul_src1, DATA_W'(c + 1));
      tick();
    end
    req_valid = '0;
    tick();
    tick();
    tick();
    settle();
    check("rr_drained", busy, 1'b0);

    // 4. Backpressure on requester 1
    do_reset();
    rsp_ready = 4'b1101;
    set_ops(1, 32'd6, 32'd7);
    req_valid = 4'b0010;
    settle();
    check("bp_grant1", req_ready, 4'b0010);
    tick();
    req_valid = '0;
    tick();
    req_valid = '1;
    for (int c = 0; c < 6; c++) begin
      settle();
      check("bp_grant", req_ready, g4[c]);
      check("bp_rsp1_held", rsp_valid[1], 1'b1);
      check("bp_result1", res(1), 32'd42);
      tick();
    end
    req_valid = '0;
    rsp_ready = '1;
    settle();
    check("bp_rsp1_before_consume", rsp_valid[1], 1'b1);
    tick();
    settle();
    check("bp_rsp1_consumed", rsp_valid[1], 1'b0);
    tick();
    tick();
    tick();
    settle();
    check("bp_drained", busy, 1'b0);

    // 5. Back-to-back on requester 3
    do_reset();
    set_ops(3, 32'd7, 32'd9);
    req_valid = 4'b1000;
    settle();
    check("b2b_first_grant", req_ready, 4'b1000);
    tick();
    set_ops(3, 32'd11, 32'd13);
    for (int c = 0; c < 5; c++) begin
      settle();
      check("b2b_grant", req_ready, g5[c]);
      check("b2b_rsp_valid", rsp_valid[3], v5[c]);
      if (v5[c]) check("b2b_result", res(3), r5[c]);
      tick();
    end
    req_valid = '0;
    tick();
    settle();
    check("b2b_drained", busy, 1'b0);

    // 6. Reset in the cycle after an accept
    do_reset();
    set_ops(2, 32'd5, 32'd5);
    req_valid = 4'b0100;
    settle();
    check("rmid_grant", req_ready, 4'b0100);
    tick();
    reset     = 1'b1;
    req_valid = 4'b1000;
    settle();
    check("rmid_ready_in_reset", req_ready, '0);
    check("rmid_src_in_reset", mul_src1, '0);
    tick();
    reset     = 1'b0;
    req_valid = '0;
    settle();
    check("rmid_rsp_dropped", rsp_valid, '0);
    check("rmid_busy", busy, 1'b0);
    tick();
    tick();
    settle();
    check("rmid_rsp_still_dropped", rsp_valid, '0);
    set_ops(1, 32'd2, 32'd3);
    set_ops(2, 32'd4, 32'd5);
    req_valid = 4'b0110;
    settle();
    check("rmid_lowest_first", req_ready, 4'b0010);
    check("rmid_src1", mul_src1, 32'd2);
    tick();
    req_valid = '0;
    tick();
    settle();
    check("rmid_post_result", res(1), 32'd6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
